// File: rtl/pipeline_exec_ctrl.sv
// Execution control FSM: run/step/stop commands, HALT drain, and the pipeline-wide stall.
// Define EXEC_CTRL_CYCLE_COUNT_EN to build the saturating advance-cycle counter.
module pipeline_exec_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_halt,
  output logic                 o_total_stall,
  output logic                 o_running,
  output logic                 o_halted,
  output logic                 o_step_done,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [2:0]     r_state;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_step_done;

  logic [2:0]     w_state_nxt;
  logic [DCW-1:0] w_drain_nxt;
  logic           w_step_done_nxt;
  logic           w_cmd_acc;

  assign w_cmd_acc = i_cmd_valid && o_cmd_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_drain_nxt     = r_drain_cnt;
    w_step_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc && i_cmd == CMD_RUN)  w_state_nxt = S_RUN;
        if (w_cmd_acc && i_cmd == CMD_STEP) w_state_nxt = S_STEP;
      end
      S_RUN, S_STEP: begin
        // HALT outranks a same-cycle STOP; a zero-length drain freezes immediately.
        if (i_halt) begin
          w_state_nxt = (DRAIN_CYCLES == 0) ? S_HALTED : S_DRAIN;
          w_drain_nxt = DCW'(DRAIN_CYCLES);
        end else if (r_state == S_STEP) begin
          w_state_nxt     = S_IDLE;
          w_step_done_nxt = 1'b1;
        end else if (w_cmd_acc && i_cmd == CMD_STOP) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        w_drain_nxt = r_drain_cnt - DCW'(1);
        if (r_drain_cnt <= DCW'(1)) w_state_nxt = S_HALTED;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_step_done <= w_step_done_nxt;
    end
  end

  assign o_running     = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
  assign o_total_stall = !o_running;
  assign o_halted      = (r_state == S_HALTED);
  assign o_cmd_ready   = (r_state == S_IDLE) || (r_state == S_RUN);
  assign o_step_done   = r_step_done;

`ifdef EXEC_CTRL_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] r_cycle_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_count <= '0;
    end else if (!o_total_stall && r_cycle_count != '1) begin
      r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
    end
  end

  assign o_cycle_count = r_cycle_count;
`else
  assign o_cycle_count = '0;
`endif

endmodule
